sr_cmd_arbiter: RTL and testbench

Upstream command stage for the set/reset flip-flop. Accepts two independent, possibly bouncing request lines (set and clear), debounces each, arbitrates between them, and issues single-cycle, mutually exclusive `s`/`r` pulses with a request/acknowledge handshake back to each requester. The block guarantees that the downstream flip-flop never sees `s=r=1` and never sees back-to-back commands closer than a programmable hold-off.

---
 rtl/sr_cmd_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sr_cmd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_arbiter.sv
// sr_cmd_arbiter: debounces set/clear requests, arbitrates between them and
// issues mutually exclusive one-cycle s/r pulses with acks and a hold-off gap.
module sr_cmd_arbiter #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned HOLDOFF    = 2,
  parameter int unsigned RR         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       set_ack,
  output logic       clr_ack,
  output logic       busy,
  output logic [7:0] conflict_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic GRANT_SET = 1'b0;
  localparam logic GRANT_CLR = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             set_armed_q, set_armed_d;
  logic             clr_armed_q, clr_armed_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;

  logic set_qual, clr_qual;
  logic grant_s, grant_r;

  assign set_qual = (set_cnt_q == DEB_MAX);
  assign clr_qual = (clr_cnt_q == DEB_MAX);

  // Per-channel debounce: count qualifying samples, re-arm on low, disarm on grant
  always_comb begin
    set_cnt_d   = set_cnt_q;
    set_armed_d = set_armed_q;
    clr_cnt_d   = clr_cnt_q;
    clr_armed_d = clr_armed_q;

    if (!set_req) begin
      set_cnt_d   = '0;
      set_armed_d = 1'b1;
    end else if (grant_s) begin
      set_cnt_d   = '0;
      set_armed_d = 1'b0;
    end else if (set_armed_q && (set_cnt_q != DEB_MAX)) begin
      set_cnt_d = set_cnt_q + CNT_W'(1);
    end

    if (!clr_req) begin
      clr_cnt_d   = '0;
      clr_armed_d = 1'b1;
    end else if (grant_r) begin
      clr_cnt_d   = '0;
      clr_armed_d = 1'b0;
    end else if (clr_armed_q && (clr_cnt_q != DEB_MAX)) begin
      clr_cnt_d = clr_cnt_q + CNT_W'(1);
    end
  end

  // Arbitration FSM: next state, grants, conflict count and registered output values
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;
    grant_s        = 1'b0;
    grant_r        = 1'b0;

    case (state_q)
      IDLE: begin
        if (set_qual && clr_qual) begin
          if (conflict_cnt_q != CNT_SAT) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
          end
          // Round-robin hands the conflict to whoever was not granted last
          if ((RR != 0) && (last_grant_q == GRANT_SET)) begin
            grant_r = 1'b1;
          end else begin
            grant_s = 1'b1;
          end
        end else if (set_qual) begin
          grant_s = 1'b1;
        end else if (clr_qual) begin
          grant_r = 1'b1;
        end

        if (grant_s) begin
          state_d      = PULSE_S;
          last_grant_d = GRANT_SET;
        end else if (grant_r) begin
          state_d      = PULSE_R;
          last_grant_d = GRANT_CLR;
        end
      end
      PULSE_S, PULSE_R: begin
        if (HOLDOFF == 0) begin
          state_d = IDLE;
        end else begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_cnt_q <= CNT_W'(1)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      set_cnt_q      <= '0;
      clr_cnt_q      <= '0;
      set_armed_q    <= 1'b1;
      clr_armed_q    <= 1'b1;
      hold_cnt_q     <= '0;
      last_grant_q   <= GRANT_CLR;
      conflict_cnt_q <= '0;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      set_cnt_q      <= set_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      set_armed_q    <= set_armed_d;
      clr_armed_q    <= clr_armed_d;
      hold_cnt_q     <= hold_cnt_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
      s_q            <= s_d;
      r_q            <= r_d;
      busy_q         <= busy_d;
    end
  end

  assign s            = s_q;
  assign set_ack      = s_q;
  assign r            = r_q;
  assign clr_ack      = r_q;
  assign busy         = busy_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// tb_sr_cmd_arbiter: directed scenarios on two arbiter configurations sharing stimulus.
// dut0: DEB=4, HOLDOFF=2, RR=0.  dut1: DEB=4, HOLDOFF=0, RR=1.
module tb_sr_cmd_arbiter;

  logic clk;
  logic rst;
  logic set_req;
  logic clr_req;

  logic       s0, r0, set_ack0, clr_ack0, busy0;
  logic [7:0] cnt0;
  logic       s1, r1, set_ack1, clr_ack1, busy1;
  logic [7:0] cnt1;

  int checks;
  int errors;

  sr_cmd_arbiter #(.DEB_CYCLES(4), .HOLDOFF(2), .RR(0)) dut0 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .s(s0), .r(r0), .set_ack(set_ack0), .clr_ack(clr_ack0),
    .busy(busy0), .conflict_cnt(cnt0)
  );

  sr_cmd_arbiter #(.DEB_CYCLES(4), .HOLDOFF(0), .RR(1)) dut1 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .s(s1), .r(r1), .set_ack(set_ack1), .clr_ack(clr_ack1),
    .busy(busy1), .conflict_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s and r must never be high together on either instance
  always @(negedge clk) begin
    checks++;
    if ((s0 & r0) === 1'b1 || (s1 & r1) === 1'b1) begin
      errors++;
      $display("FAIL invariant s&r t=%0t dut0 %b%b dut1 %b%b exp no overlap", $time, s0, r0, s1, r1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s0, r0, set_ack0, clr_ack0, busy0} !== 5'b0 || cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL reset dut0 got %b%b%b%b%b cnt %0d exp all 0", s0, r0, set_ack0, clr_ack0, busy0, cnt0);
    end
    checks++;
    if ({s1, r1, set_ack1, clr_ack1, busy1} !== 5'b0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset dut1 got %b%b%b%b%b cnt %0d exp all 0", s1, r1, set_ack1, clr_ack1, busy1, cnt1);
    end
  endtask

  task automatic test_single_set();
    logic exp_s, exp_b0, exp_b1;
    do_reset();
    set_req = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      exp_s  = (e == 4);
      exp_b0 = (e >= 4 && e <= 6);
      exp_b1 = (e == 4);
      checks++;
      if (s0 !== exp_s || set_ack0 !== exp_s || r0 !== 1'b0 || clr_ack0 !== 1'b0) begin
        errors++;
        $display("FAIL single dut0 edge %0d s/ack/r %b%b%b exp %b%b0", e, s0, set_ack0, r0, exp_s, exp_s);
      end
      checks++;
      if (busy0 !== exp_b0) begin
        errors++;
        $display("FAIL single busy0 edge %0d got %b exp %b", e, busy0, exp_b0);
      end
      checks++;
      if (s1 !== exp_s || set_ack1 !== exp_s || busy1 !== exp_b1) begin
        errors++;
        $display("FAIL single dut1 edge %0d s/ack/busy %b%b%b exp %b%b%b", e, s1, set_ack1, busy1, exp_s, exp_s, exp_b1);
      end
    end
    set_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_bounce();
    logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_s;
    do_reset();
    for (int e = 0; e < 12; e++) begin
      set_req = (e < 7) ? pat[e] : 1'b1;
      tick();
      exp_s = (e == 7);
      checks++;
      if (s0 !== exp_s || r0 !== 1'b0 || s1 !== exp_s || r1 !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge %0d s0 r0 s1 r1 %b%b%b%b exp %b0%b0", e, s0, r0, s1, r1, exp_s, exp_s);
      end
    end
    set_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_short_req();
    do_reset();
    for (int e = 0; e < 12; e++) begin
      set_req = (e < 3);
      tick();
      checks++;
      if (s0 !== 1'b0 || busy0 !== 1'b0 || s1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL short edge %0d s0 busy0 s1 busy1 %b%b%b%b exp 0000", e, s0, busy0, s1, busy1);
      end
    end
  endtask

  // Both raised at edge 0; dut0 loser at winner+HOLDOFF+2=8, dut1 at winner+2=6
  task automatic run_conflict(input string tag, input logic d1_set_first, input logic [7:0] exp_cnt);
    logic es0, er0, es1, er1;
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int e = 0; e < 14; e++) begin
      tick();
      es0 = (e == 4);
      er0 = (e == 8);
      es1 = d1_set_first ? (e == 4) : (e == 6);
      er1 = d1_set_first ? (e == 6) : (e == 4);
      checks++;
      if (s0 !== es0 || r0 !== er0 || clr_ack0 !== er0) begin
        errors++;
        $display("FAIL %s dut0 edge %0d s r ack %b%b%b exp %b%b%b", tag, e, s0, r0, clr_ack0, es0, er0, er0);
      end
      checks++;
      if (s1 !== es1 || r1 !== er1 || clr_ack1 !== er1) begin
        errors++;
        $display("FAIL %s dut1 edge %0d s r ack %b%b%b exp %b%b%b", tag, e, s1, r1, clr_ack1, es1, er1, er1);
      end
    end
    checks++;
    if (cnt0 !== exp_cnt || cnt1 !== exp_cnt) begin
      errors++;
      $display("FAIL %s conflict_cnt got %0d/%0d exp %0d", tag, cnt0, cnt1, exp_cnt);
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    run_conflict("conflict", 1'b1, 8'd1);
  endtask

  task automatic test_round_robin();
    do_reset();
    clr_req = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (r1 !== (e == 4) || s1 !== 1'b0) begin
        errors++;
        $display("FAIL rr clr-alone edge %0d r1 s1 %b%b exp %b0", e, r1, s1, (e == 4));
      end
    end
    clr_req = 1'b0;
    tick();
    tick();
    run_conflict("rr_after_clr", 1'b1, 8'd1);
    set_req = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (s1 !== (e == 4) || r1 !== 1'b0) begin
        errors++;
        $display("FAIL rr set-alone edge %0d s1 r1 %b%b exp %b0", e, s1, r1, (e == 4));
      end
    end
    set_req = 1'b0;
    tick();
    tick();
    run_conflict("rr_after_set", 1'b0, 8'd2);
  endtask

  task automatic test_drop_pending();
    do_reset();
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int e = 0; e < 14; e++) begin
      if (e == 5) clr_req = 1'b0;
      tick();
      checks++;
      if (s0 !== (e == 4) || r0 !== 1'b0 || r1 !== 1'b0) begin
        errors++;
        $display("FAIL drop edge %0d s0 r0 r1 %b%b%b exp %b00", e, s0, r0, r1, (e == 4));
      end
    end
    set_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      set_req = 1'b1;
      clr_req = 1'b1;
      for (int e = 0; e < 14; e++) tick();
      set_req = 1'b0;
      clr_req = 1'b0;
      tick();
      tick();
      if (i == 9) begin
        checks++;
        if (cnt0 !== 8'd10 || cnt1 !== 8'd10) begin
          errors++;
          $display("FAIL sat_10 conflict_cnt got %0d/%0d exp 10", cnt0, cnt1);
        end
      end
    end
    checks++;
    if (cnt0 !== 8'd255 || cnt1 !== 8'd255) begin
      errors++;
      $display("FAIL saturation conflict_cnt got %0d/%0d exp 255", cnt0, cnt1);
    end
  endtask

  // Runs straight after saturation so the reset also has a counter to clear
  task automatic test_reset_midop();
    set_req = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    checks++;
    if (s0 !== 1'b1 || s1 !== 1'b1) begin
      errors++;
      $display("FAIL midop pulse s0 s1 %b%b exp 11", s0, s1);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({s0, r0, set_ack0, clr_ack0, busy0} !== 5'b0 || cnt0 !== 8'd0 ||
        {s1, r1, set_ack1, clr_ack1, busy1} !== 5'b0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL midop reset outs %b%b%b%b%b/%b%b%b%b%b cnt %0d/%0d exp 0",
               s0, r0, set_ack0, clr_ack0, busy0, s1, r1, set_ack1, clr_ack1, busy1, cnt0, cnt1);
    end
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (s0 !== (e == 5) || s1 !== (e == 5)) begin
        errors++;
        $display("FAIL midop refire edge %0d s0 s1 %b%b exp %b", e, s0, s1, (e == 5));
      end
    end
    set_req = 1'b0;
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    test_reset();
    test_single_set();
    test_bounce();
    test_short_req();
    test_conflict();
    test_round_robin();
    test_drop_pending();
    test_saturation();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
